// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch stage in front of an asynchronous ROM.
//
// A two-phase FETCH/EXECUTE machine paces the stage. FETCH latches the ROM
// word at pc_addr, splits it into instr/oprnd, bumps the PC and pulses
// fetch_valid. EXECUTE optionally takes a jump (load/load_addr). Each
// instruction therefore costs two enabled cycles.
//
// Optional feature: define FETCH_HALT_EN to add a HALT state. A fetched word
// whose instr field is all ones parks the machine in HALT. Only reset leaves
// HALT. Without the macro, that opcode is treated like any other.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; overrides every other input
//   enable      run enable; low holds all state (fetch_valid drops)
//   load        jump request, honoured only in EXECUTE
//   load_addr   jump target
//   rom_data    combinational ROM read data at pc_addr
//   pc_addr     program counter / ROM address
//   instr       upper half of the latched word
//   oprnd       lower half of the latched word
//   phase       0 = FETCH, 1 = EXECUTE (and HALT)
//   fetch_valid one-cycle pulse after instr/oprnd update
module pc_fetch #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]   pc_addr,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic                phase,
  output logic                fetch_valid
);

  localparam int H = DATA_W / 2;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1
`ifdef FETCH_HALT_EN
    ,HALT   = 2'd2
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [H-1:0]        instr_nxt, oprnd_nxt;
  logic                fv_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc_addr     <= RESET_ADDR;
      instr       <= '0;
      oprnd       <= '0;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_addr     <= pc_nxt;
      instr       <= instr_nxt;
      oprnd       <= oprnd_nxt;
      fetch_valid <= fv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_addr;
    instr_nxt = instr;
    oprnd_nxt = oprnd;
    fv_nxt    = 1'b0;          // pulse only; cleared on every non-fetch edge
    if (enable) begin
      case (state)
        FETCH: begin
          instr_nxt = rom_data[DATA_W-1:H];
          oprnd_nxt = rom_data[H-1:0];
          pc_nxt    = pc_addr + {{(ADDR_W-1){1'b0}}, 1'b1};  // wraps mod 2^ADDR_W
          fv_nxt    = 1'b1;
          state_nxt = EXECUTE;
`ifdef FETCH_HALT_EN
          if (&rom_data[DATA_W-1:H]) state_nxt = HALT;
`endif
        end
        EXECUTE: begin
          if (load) pc_nxt = load_addr;
          state_nxt = FETCH;
        end
        default: begin
          // HALT (when present) holds everything; unreachable codes recover.
`ifdef FETCH_HALT_EN
          if (state != HALT) state_nxt = FETCH;
`else
          state_nxt = FETCH;
`endif
        end
      endcase
    end
  end

  // EXECUTE and HALT both report phase 1.
  assign phase = (state != FETCH);

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch stage that sits directly upstream of the 4096×8 program ROM. It drives the ROM's 12-bit address, samples the 8-bit ROM word on the fetch edge, and splits it into a 4-bit instruction nibble and a 4-bit operand nibble for the downstream decoder. A two-phase FETCH/EXECUTE state machine paces the stage. Jumps are accepted during EXECUTE.

## Interface

Parameters:
- ADDR_W, 12, program counter / ROM address width
- DATA_W, 8, ROM word width; must be even, split into two equal halves
- RESET_ADDR, 12'h000, PC value after reset

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; has priority over every other input
- enable  input  1  run enable; when low, all state holds
- load  input  1  jump request, honoured only in EXECUTE
- load_addr  input  ADDR_W  jump target
- rom_data  input  DATA_W  combinational read data from the ROM at pc_addr
- pc_addr  output  ADDR_W  program counter, wired to the ROM address
- instr  output  DATA_W/2  upper half of the latched word (rom_data[7:4])
- oprnd  output  DATA_W/2  lower half of the latched word (rom_data[3:0])
- phase  output  1  0 = FETCH, 1 = EXECUTE
- fetch_valid  output  1  one-cycle pulse; instr/oprnd were just updated

## Operation

- Reset values: pc_addr = RESET_ADDR, instr = 0, oprnd = 0, phase = 0 (FETCH), fetch_valid = 0.
- States: FETCH, EXECUTE, and HALT (HALT exists only with the macro; see Configuration).
- FETCH with enable=1:
  - instr/oprnd ← rom_data
  - pc_addr ← pc_addr + 1
  - fetch_valid ← 1
  - next state EXECUTE
  - load is ignored in FETCH.
- EXECUTE with enable=1:
  - fetch_valid ← 0
  - if load=1, pc_addr ← load_addr, otherwise pc_addr holds
  - next state FETCH
- enable=0 in any state: all registers hold, and fetch_valid is forced to 0 on that edge.
- PC arithmetic is modulo 2^ADDR_W: 12'hFFF + 1 = 12'h000. No flag and no stall on wrap.
- A load to the address that was just fetched is legal and causes a refetch.
- Reset asserted mid-instruction, in any state: on the next edge every output takes its reset value and the FSM returns to FETCH.

## Timing

- The ROM is asynchronous. rom_data must be stable within the same cycle that pc_addr is presented, and it is sampled at the FETCH→EXECUTE edge.
- Each instruction takes 2 enabled cycles. Throughput is one instruction per 2 cycles.
- instr/oprnd/fetch_valid are valid 1 cycle after the FETCH edge and stay valid through EXECUTE. instr/oprnd hold until the next fetch.
- A jump takes effect at the EXECUTE→FETCH edge. The next fetched word comes from load_addr, with zero-cycle penalty beyond the normal 2-cycle rhythm.
- When reset and enable are both high, reset wins. When reset and load are both high, reset wins.

## Configuration

- FETCH_HALT_EN defined:
  - In FETCH, a fetched word with instr == 4'hF moves the FSM to HALT instead of EXECUTE.
  - The word is still latched, fetch_valid still pulses, and the PC still increments.
  - In HALT, phase = 1, fetch_valid = 0, and all registers hold regardless of enable and load.
  - Only reset leaves HALT.
- FETCH_HALT_EN undefined: there is no HALT state, and opcode 4'hF is treated like any other opcode.

## Test plan

- Reset then run with ROM[0]=8'h3A, ROM[1]=8'h5C, enable=1 → cycle 1: instr=3, oprnd=A, pc_addr=1, fetch_valid=1. Cycle 3: instr=5, oprnd=C, pc_addr=2.
- Jump: in EXECUTE after fetching ROM[1], drive load=1, load_addr=12'h7F0, with ROM[12'h7F0]=8'h91 → next fetch gives instr=9, oprnd=1, pc_addr=12'h7F1. The same load asserted during FETCH → ignored.
- Wrap: load_addr=12'hFFF, ROM[12'hFFF]=8'h22 → after fetch pc_addr=12'h000, instr=2, oprnd=2.
- Stall: drop enable for 3 cycles during EXECUTE → pc_addr, instr, oprnd and phase unchanged, fetch_valid=0. On resume, the sequence continues exactly where it stopped.
- Mid-run reset: assert reset for 1 cycle in EXECUTE with pc_addr=12'h005 → next edge gives pc_addr=12'h000, instr=0, oprnd=0, phase=0, fetch_valid=0.
- With FETCH_HALT_EN, ROM[2]=8'hF0 → after that fetch phase=1 and pc_addr=3, frozen for 10 cycles despite enable=1 and load=1. Reset releases it. Without the macro, the sequence proceeds normally.
